aud_player: RTL and testbench
=============================

# aud_player

Playback engine for the audio path: reads 16-bit signed PCM samples from the 1M-word SRAM and serialises them MSB-first onto the codec DAC data line, framed by the codec's DAC LR clock. It is the transmit-side counterpart of the recorder; both share the same SRAM, and the top-level FSM arbitrates between them. Supports pause/resume, stop, fast playback (address skipping) and slow playback (sample repetition).

## Interface
- `DATA_W`, 16: sample width (bits per channel slot).
- `ADDR_W`, 20: SRAM word address width.

- `i_clk` in 1: codec bit clock domain clock; the only clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_lrc` in 1: DAC LR clock. Low = left slot, high = right slot.
- `i_start` in 1: 1-cycle pulse. Begins playback from IDLE or resumes from PAUSE.
- `i_pause` in 1: 1-cycle pulse. Requests pause.
- `i_stop` in 1: 1-cycle pulse. Aborts playback.
- `i_end_addr` in ADDR_W: last valid sample address. Sampled at start.
- `i_fast` in 1: fast mode select.
- `i_slow` in 1: slow mode select. If both `i_fast` and `i_slow` are set, `i_fast` wins.
- `i_speed` in 3: rate factor k. Effective factor is k+1.
- `i_sram_data` in DATA_W: SRAM read data. Valid in the same cycle as `o_address`.
- `o_address` out ADDR_W: SRAM read address.
- `o_dac_data` out 1: serial DAC data.
- `o_playing` out 1: high in every state except IDLE.
- `o_done` out 1: 1-cycle pulse when the end address finishes playing.

## Operation
- **States:** IDLE, WAIT, SHIFT, HOLD, PAUSE.
- **Edge detection:** `lrc_d` is `i_lrc` registered. An edge exists when `i_lrc != lrc_d`.
- **IDLE:**
  - On `i_start`: latch `i_end_addr`, set address to 0, go to WAIT.
  - Other inputs are ignored.
- **WAIT:** on a falling edge:
  - Load `shift_r <= i_sram_data`.
  - Clear bit counter `cnt_r`.
  - Set `slot_r <= L`.
  - Go to SHIFT.
  - Rising edges are ignored, so playback always starts with the left slot.
- **SHIFT:**
  - Each cycle, shift `shift_r` left by 1 and increment `cnt_r`.
  - After 16 bits, go to HOLD.
  - Edges seen during SHIFT are ignored.
- **HOLD, slot L:** on a rising edge, reload the same sample and go to SHIFT with `slot_r <= R`. The mono sample is duplicated to both slots.
- **Frame end:** the cycle HOLD is entered after the R slot. Apply the address update:
  - Normal mode (neither `i_fast` nor `i_slow`): address + 1.
  - Fast mode: address + (k+1).
  - Slow mode: `rep_r` counts frames. While `rep_r < k`, increment `rep_r` and keep the address. Otherwise clear `rep_r` and use address + 1.
  - The next address is computed ADDR_W+1 bits wide. If it is greater than the end address, or the address already equals `0xFFFFF` and would advance:
    - Pulse `o_done`.
    - Set address to 0.
    - Go to IDLE.
  - Otherwise go to WAIT. Then the next frame loads on the next falling edge.
- **Pause:**
  - `i_pause` sets a pending flag.
  - The flag is honoured at frame end: go to PAUSE instead of WAIT, with the address already advanced.
  - A pause request made during WAIT goes to PAUSE immediately.
  - In PAUSE, `i_start` goes to WAIT. `i_pause` is ignored.
- **Stop:**
  - `i_stop` in any non-IDLE state, including mid-SHIFT, forces IDLE on the next edge.
  - Clears address, shift register, `rep_r` and the pause flag.
  - `o_done` does not pulse.
  - `i_stop` has priority over `i_start`/`i_pause` in the same cycle.
- **Output gating:** `o_dac_data = shift_r[15]` in SHIFT, else 0.

## Timing
- **Reset values:** state IDLE; `o_address` 0; `o_dac_data` 0; `o_playing` 0; `o_done` 0. All internal registers are 0.
- **Load latency:** edge observed in cycle t → MSB on `o_dac_data` in cycle t+1 → LSB in cycle t+16.
- **Address timing:**
  - `o_address` is registered.
  - It is stable from frame end until the next load.
  - `i_sram_data` is sampled only in the edge cycle.
- **`o_done`:** asserted for exactly the cycle after the last R-slot bit.
- **Mode inputs:** `i_fast`, `i_slow`, `i_speed` are sampled only at frame end. Mid-frame changes take effect at the next address update.
- **Reset mid-operation:** reset wins over every input. Outputs reach reset values in the following cycle.

## Structure
- **Package `aud_pkg`:**
  - State enum `player_state_t`.
  - `AUD_DATA_W` = 16.
  - `AUD_ADDR_W` = 20.
  - `AUD_ADDR_MAX` = 20'hFFFFF.
  - Shared with the recorder.
- **Sub-module `aud_lrc_edge`:**
  - Registers `i_lrc`.
  - Outputs `o_rise` and `o_fall` pulses.
  - Reused by the recorder rework.

## Test plan
- **Normal playback:** SRAM[0..2] = 16'hA5F0, 16'h0001, 16'h8000; `i_end_addr` = 2; `i_start`.
  - Each word appears twice (L then R), MSB-first, starting 1 cycle after each LRC edge.
  - `o_address` steps 0→1→2.
  - `o_done` pulses once.
  - Address returns to 0.
- **Fast mode:** `i_fast` = 1, `i_speed` = 1, `i_end_addr` = 5 → addresses 0, 2, 4 played; `o_done` after address 4.
- **Slow mode:** `i_slow` = 1, `i_speed` = 2, `i_end_addr` = 1 → address 0 for 3 frames, address 1 for 3 frames, then `o_done`.
- **Pause/resume:** pause mid-SHIFT of address 3.
  - Address 3 completes both slots.
  - PAUSE is entered with address 4; output stays 0 for 10 LRC periods.
  - `i_start` → address 4 is played on the next falling edge.
- **Stop:**
  - `i_stop` at bit 7 of an R slot → next cycle IDLE, `o_dac_data` 0, `o_address` 0, no `o_done`.
  - Simultaneous `i_stop` and `i_start` → IDLE.
- **Reset mid-frame:** assert `i_rst` during SHIFT → all outputs 0 next cycle; a fresh `i_start` plays from address 0.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio-path definitions for the player and recorder.
// Contents: sample/address widths, address ceiling, slot encoding and
// the player FSM state type.
package aud_pkg;

   localparam int unsigned AUD_DATA_W = 16;
   localparam int unsigned AUD_ADDR_W = 20;
   localparam logic [AUD_ADDR_W-1:0] AUD_ADDR_MAX = 20'hFFFFF;

   // LR clock slot: low = left, high = right
   localparam logic SLOT_L = 1'b0;
   localparam logic SLOT_R = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_PAUSE = 3'd4
   } player_state_t;

endpackage

// File: rtl/aud_lrc_edge.sv
// LR clock edge detector.
// Ports: i_clk, i_rst (sync, active-high), i_lrc (LR clock in),
//        o_rise / o_fall (high in the cycle i_lrc differs from its registered copy).
module aud_lrc_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_lrc,
   output logic o_rise,
   output logic o_fall
);

   logic lrc_d;

   // Previous-cycle copy of the LR clock
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lrc_d <= 1'b0;
      end else begin
         lrc_d <= i_lrc;
      end
   end

   // Edge is visible in the same cycle the new level arrives
   assign o_rise = i_lrc & ~lrc_d;
   assign o_fall = ~i_lrc & lrc_d;

endmodule

// File: rtl/aud_player.sv
// Audio playback engine: reads PCM words from SRAM and serialises them
// MSB-first onto the DAC data line, one copy per LR slot.
// Ports: i_clk, i_rst (sync, active-high), i_lrc (DAC LR clock),
//        i_start/i_pause/i_stop (1-cycle controls), i_end_addr (last sample),
//        i_fast/i_slow/i_speed (rate control), i_sram_data (read data),
//        o_address (SRAM read address), o_dac_data (serial data),
//        o_playing (not idle), o_done (end of playback pulse).
module aud_player
   import aud_pkg::*;
#(
   parameter int unsigned DATA_W = AUD_DATA_W,
   parameter int unsigned ADDR_W = AUD_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_lrc,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic              i_fast,
   input  logic              i_slow,
   input  logic [2:0]        i_speed,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_dac_data,
   output logic              o_playing,
   output logic              o_done
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam int unsigned AW1   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   player_state_t     state_r, nxt_state;
   logic [DATA_W-1:0] shift_r, nxt_shift;
   logic [CNT_W-1:0]  cnt_r, nxt_cnt;
   logic              slot_r, nxt_slot;
   logic [2:0]        rep_r, nxt_rep;
   logic              pause_r, nxt_pause;
   logic [ADDR_W-1:0] end_r, nxt_end;
   logic [ADDR_W-1:0] nxt_addr;
   logic              nxt_dac, nxt_done;

   logic              lrc_rise, lrc_fall;

   logic [AW1-1:0]    fe_addr;
   logic              fe_adv;
   logic [2:0]        fe_rep;
   logic              fe_done;

   aud_lrc_edge u_lrc_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_lrc  (i_lrc),
      .o_rise (lrc_rise),
      .o_fall (lrc_fall)
   );

   // Frame-end address step; one extra bit so wrap past the top is visible
   always_comb begin
      fe_adv  = 1'b1;
      fe_rep  = '0;
      fe_addr = {1'b0, o_address} + AW1'(1);
      if (i_fast) begin
         fe_addr = {1'b0, o_address} + AW1'(i_speed) + AW1'(1);
      end else if (i_slow && (rep_r < i_speed)) begin
         fe_adv  = 1'b0;
         fe_rep  = rep_r + 3'd1;
         fe_addr = {1'b0, o_address};
      end
      fe_done = fe_adv && ((fe_addr > {1'b0, end_r}) || (o_address == {ADDR_W{1'b1}}));
   end

   // Next-state and next-output logic
   always_comb begin
      nxt_state = state_r;
      nxt_shift = shift_r;
      nxt_cnt   = cnt_r;
      nxt_slot  = slot_r;
      nxt_rep   = rep_r;
      nxt_pause = pause_r;
      nxt_end   = end_r;
      nxt_addr  = o_address;
      nxt_dac   = 1'b0;
      nxt_done  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               nxt_end   = i_end_addr;
               nxt_addr  = '0;
               nxt_rep   = '0;
               nxt_pause = 1'b0;
               nxt_state = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // Pause here takes effect at once; only a falling edge starts a frame
            if (i_pause || pause_r) begin
               nxt_pause = 1'b0;
               nxt_state = ST_PAUSE;
            end else if (lrc_fall) begin
               nxt_shift = i_sram_data;
               nxt_cnt   = '0;
               nxt_slot  = SLOT_L;
               nxt_dac   = i_sram_data[DATA_W-1];
               nxt_state = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (i_pause) begin
               nxt_pause = 1'b1;
            end
            nxt_shift = shift_r << 1;
            nxt_cnt   = cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
               if (slot_r == SLOT_L) begin
                  nxt_state = ST_HOLD;
               end else if (fe_done) begin
                  nxt_done  = 1'b1;
                  nxt_addr  = '0;
                  nxt_rep   = '0;
                  nxt_pause = 1'b0;
                  nxt_state = ST_IDLE;
               end else begin
                  nxt_addr = fe_addr[ADDR_W-1:0];
                  nxt_rep  = fe_rep;
                  if (pause_r || i_pause) begin
                     nxt_pause = 1'b0;
                     nxt_state = ST_PAUSE;
                  end else begin
                     nxt_state = ST_WAIT;
                  end
               end
            end else begin
               nxt_dac = shift_r[DATA_W-2];
            end
         end

         ST_HOLD: begin
            // Left slot done; replay the same word in the right slot
            if (i_pause) begin
               nxt_pause = 1'b1;
            end
            if (lrc_rise) begin
               nxt_shift = i_sram_data;
               nxt_cnt   = '0;
               nxt_slot  = SLOT_R;
               nxt_dac   = i_sram_data[DATA_W-1];
               nxt_state = ST_SHIFT;
            end
         end

         ST_PAUSE: begin
            if (i_start) begin
               nxt_state = ST_WAIT;
            end
         end

         default: begin
            nxt_state = ST_IDLE;
         end
      endcase

      // Stop overrides everything else outside IDLE
      if (i_stop && (state_r != ST_IDLE)) begin
         nxt_state = ST_IDLE;
         nxt_addr  = '0;
         nxt_shift = '0;
         nxt_cnt   = '0;
         nxt_slot  = SLOT_L;
         nxt_rep   = '0;
         nxt_pause = 1'b0;
         nxt_dac   = 1'b0;
         nxt_done  = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r    <= ST_IDLE;
         shift_r    <= '0;
         cnt_r      <= '0;
         slot_r     <= SLOT_L;
         rep_r      <= '0;
         pause_r    <= 1'b0;
         end_r      <= '0;
         o_address  <= '0;
         o_dac_data <= 1'b0;
         o_playing  <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         state_r    <= nxt_state;
         shift_r    <= nxt_shift;
         cnt_r      <= nxt_cnt;
         slot_r     <= nxt_slot;
         rep_r      <= nxt_rep;
         pause_r    <= nxt_pause;
         end_r      <= nxt_end;
         o_address  <= nxt_addr;
         o_dac_data <= nxt_dac;
         o_playing  <= (nxt_state != ST_IDLE);
         o_done     <= nxt_done;
      end
   end

endmodule

// File: tb/tb_aud_player.sv
// Bench for aud_player: SRAM model, LR clock generator, frame-level
// reference model feeding an expected-slot queue, and a serial monitor.
module tb_aud_player;

   localparam int HALF = 20;

   typedef struct {
      logic [19:0] addr;
      logic [15:0] data;
      int          nbits;
      bit          need_fall;
      bit          last;
   } slot_t;

   logic        clk;
   logic        rst;
   logic        lrc;
   logic        start, pause, stop;
   logic [19:0] end_addr;
   logic        fast, slow;
   logic [2:0]  speed;
   logic [15:0] sram_data;
   logic [19:0] address;
   logic        dac_data, playing, done;

   logic [15:0] mem [64];
   slot_t       exp_q [$];

   int          n_total, n_bad;
   int          cyc, cap_left, done_cyc;
   slot_t       cur;
   logic [15:0] got;
   bit          addr_ok, play_ok, prev_lrc, mon_en;
   event        ev_edge;

   aud_player dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_lrc       (lrc),
      .i_start     (start),
      .i_pause     (pause),
      .i_stop      (stop),
      .i_end_addr  (end_addr),
      .i_fast      (fast),
      .i_slow      (slow),
      .i_speed     (speed),
      .i_sram_data (sram_data),
      .o_address   (address),
      .o_dac_data  (dac_data),
      .o_playing   (playing),
      .o_done      (done)
   );

   assign sram_data = mem[address[5:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // LR clock: toggles just after a rising clock edge every HALF cycles
   initial begin
      lrc = 1'b0;
      forever begin
         repeat (HALF) @(posedge clk);
         #1 lrc = ~lrc;
         -> ev_edge;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic push_slot(input int a, input int nb, input bit nf, input bit last);
      slot_t s;
      s.addr      = 20'(a);
      s.data      = mem[a % 64];
      s.nbits     = nb;
      s.need_fall = nf;
      s.last      = last;
      exp_q.push_back(s);
   endtask

   // Reference model: frame addresses from first up to end (excl. stop_before)
   task automatic push_range(input int first, input int stop_before, input int end_a,
                             input bit f, input bit s, input int k);
      int  a;
      int  reps;
      int  nxt;
      bit  nf;
      a  = first;
      nf = 1'b1;
      while (a <= end_a && a < stop_before) begin
         reps = (s && !f) ? k + 1 : 1;
         nxt  = f ? a + k + 1 : a + 1;
         for (int r = 0; r < reps; r++) begin
            push_slot(a, 16, nf, 1'b0);
            nf = 1'b0;
            push_slot(a, 16, 1'b0, (r == reps - 1) && (nxt > end_a));
         end
         a = nxt;
      end
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
   endtask

   // Pulses start just after a rising LR edge so the next falling edge is far off
   task automatic do_start(input int e, input bit f, input bit s, input int k);
      end_addr = 20'(e);
      fast     = f;
      slow     = s;
      speed    = 3'(k);
      do @(ev_edge); while (lrc !== 1'b1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(ev_edge);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || cap_left != 0 || cyc <= done_cyc) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         n_total++;
         n_bad++;
         $display("FAIL drain_timeout actual=%0d required=0 slots left", exp_q.size());
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic run_case(input int e, input bit f, input bit s, input int k);
      do_start(e, f, s, k);
      push_range(0, 1 << 20, e, f, s, k);
      wait_drain();
   endtask

   // Monitor: deserialises each slot after an LR edge and scores it
   initial begin
      cyc      = 0;
      cap_left = 0;
      done_cyc = -1;
      prev_lrc = 1'b0;
      got      = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en) begin
            chk("o_done", {31'd0, done}, {31'd0, (cyc == done_cyc)});
            if (cyc == done_cyc) begin
               chk("done_addr", {12'd0, address}, 32'd0);
               chk("done_playing", {31'd0, playing}, 32'd0);
            end
            if (cap_left == 0) begin
               chk("idle_dac", {31'd0, dac_data}, 32'd0);
            end else begin
               got = {got[14:0], dac_data};
               if (address !== cur.addr) addr_ok = 1'b0;
               if (playing !== 1'b1) play_ok = 1'b0;
               cap_left--;
               if (cap_left == 0) begin
                  chk("slot_data", {16'd0, got}, {16'd0, cur.data >> (16 - cur.nbits)});
                  chk("slot_addr", {31'd0, addr_ok}, 32'd1);
                  chk("slot_playing", {31'd0, play_ok}, 32'd1);
                  if (cur.last) done_cyc = cyc + 1;
               end
            end
            if (lrc != prev_lrc && cap_left == 0 && exp_q.size() > 0) begin
               if (!exp_q[0].need_fall || lrc == 1'b0) begin
                  cur      = exp_q.pop_front();
                  cap_left = cur.nbits;
                  got      = '0;
                  addr_ok  = 1'b1;
                  play_ok  = 1'b1;
               end
            end
         end
         prev_lrc = lrc;
      end
   end

   initial begin
      n_total  = 0;
      n_bad    = 0;
      mon_en   = 1'b0;
      rst      = 1'b1;
      start    = 1'b0;
      pause    = 1'b0;
      stop     = 1'b0;
      end_addr = '0;
      fast     = 1'b0;
      slow     = 1'b0;
      speed    = '0;
      randomize_mem();
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_addr", {12'd0, address}, 32'd0);
      chk("rst_dac", {31'd0, dac_data}, 32'd0);
      chk("rst_playing", {31'd0, playing}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      mon_en = 1'b1;

      // Directed rate cases
      mem[0] = 16'hA5F0;
      mem[1] = 16'h0001;
      mem[2] = 16'h8000;
      run_case(2, 1'b0, 1'b0, 0);
      randomize_mem();
      run_case(5, 1'b1, 1'b0, 1);
      run_case(1, 1'b0, 1'b1, 2);
      run_case(4, 1'b1, 1'b1, 2);
      run_case(0, 1'b0, 1'b0, 0);

      // Randomised rate cases
      for (int i = 0; i < 4; i++) begin
         int e, m, k;
         randomize_mem();
         e = int'($urandom_range(0, 6));
         m = int'($urandom_range(0, 3));
         k = int'($urandom_range(0, 3));
         run_case(e, m[0], m[1], k);
      end

      // Pause during address 3, hold for 10 LR periods, resume at 4
      randomize_mem();
      do_start(6, 1'b0, 1'b0, 0);
      push_range(0, 4, 6, 1'b0, 1'b0, 0);
      wait_edges(7);
      repeat (5) @(posedge clk);
      #1 pause = 1'b1;
      chk("pause_req_addr", {12'd0, address}, 32'd3);
      @(posedge clk);
      #1 pause = 1'b0;
      wait_edges(2);
      chk("paused_addr", {12'd0, address}, 32'd4);
      chk("paused_playing", {31'd0, playing}, 32'd1);
      wait_edges(19);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      push_range(4, 1 << 20, 6, 1'b0, 1'b0, 0);
      wait_drain();

      // Stop at bit 7 of the right slot of address 0
      randomize_mem();
      do_start(4, 1'b0, 1'b0, 0);
      push_slot(0, 16, 1'b1, 1'b0);
      push_slot(0, 9, 1'b0, 1'b0);
      wait_edges(2);
      repeat (9) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      chk("stop_dac", {31'd0, dac_data}, 32'd0);
      chk("stop_addr", {12'd0, address}, 32'd0);
      chk("stop_playing", {31'd0, playing}, 32'd0);
      wait_edges(4);
      chk("stop_idle", {31'd0, playing}, 32'd0);

      // Stop and start together while paused
      do_start(4, 1'b0, 1'b0, 0);
      pause = 1'b1;
      @(posedge clk);
      #1 pause = 1'b0;
      chk("wait_pause_playing", {31'd0, playing}, 32'd1);
      repeat (3) @(posedge clk);
      #1 stop = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      start = 1'b0;
      chk("stopstart_playing", {31'd0, playing}, 32'd0);
      wait_edges(3);
      chk("stopstart_idle", {31'd0, playing}, 32'd0);

      // Reset during the left slot, then a fresh playback
      randomize_mem();
      do_start(4, 1'b0, 1'b0, 0);
      push_slot(0, 5, 1'b1, 1'b0);
      wait_edges(1);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_dac", {31'd0, dac_data}, 32'd0);
      chk("midrst_addr", {12'd0, address}, 32'd0);
      chk("midrst_playing", {31'd0, playing}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      run_case(1, 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
